// File: rtl/ls_queue_p.sv
// ls_queue_p -- in-order load/store queue between the dispatcher and the LSU.
//
// Entries are held in a circular buffer [head, tail). Each entry tracks two
// source operands (base, store data) that are captured or woken up from the
// CDB result buses. Only the head entry may issue: loads go out speculatively
// unless they target the memory-mapped IO address, stores wait for ROB commit.
// A mispredict flush drops every uncommitted entry; committed entries always
// form a contiguous run starting at head, so they are kept in place.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; all state holds while low
//   flush               mispredict rollback
//   disp_*              new entry written at tail when disp_valid
//   cdb_valid/rob_id/data  NUM_CDB flat-packed result buses
//   commit_valid/rob_id ROB commit notification
//   rob_head_id         tag at ROB head (gates IO loads)
//   lsu_busy            LSU back-pressure
//   lsu_*               registered issue outputs, lsu_valid is a 1-cycle pulse
//   io_rob_id           tag of a ready head entry addressing IO, else 0
//   count, full         occupancy and almost-full flag
module ls_queue_p #(
    parameter int DEPTH       = 16,
    parameter int ROB_ID_W    = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 4,
    parameter int NUM_CDB     = 2,
    parameter int FULL_MARGIN = 3,
    parameter logic [DATA_W-1:0] IO_ADDR = DATA_W'('h30000)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic                        disp_is_store,
    input  logic [OP_W-1:0]             disp_op,
    input  logic [ROB_ID_W-1:0]         disp_q1,
    input  logic [ROB_ID_W-1:0]         disp_q2,
    input  logic [DATA_W-1:0]           disp_v1,
    input  logic [DATA_W-1:0]           disp_v2,
    input  logic [DATA_W-1:0]           disp_imm,
    input  logic [ROB_ID_W-1:0]         disp_rob_id,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic                        commit_valid,
    input  logic [ROB_ID_W-1:0]         commit_rob_id,
    input  logic [ROB_ID_W-1:0]         rob_head_id,
    input  logic                        lsu_busy,
    output logic                        lsu_valid,
    output logic [OP_W-1:0]             lsu_op,
    output logic                        lsu_is_store,
    output logic [DATA_W-1:0]           lsu_addr,
    output logic [DATA_W-1:0]           lsu_wdata,
    output logic [ROB_ID_W-1:0]         lsu_rob_id,
    output logic [ROB_ID_W-1:0]         io_rob_id,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Control state
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] cmt_q, cmt_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Entry payload (no reset needed: qualified by busy_q)
    logic                st_q  [DEPTH];
    logic [OP_W-1:0]     op_q  [DEPTH];
    logic [ROB_ID_W-1:0] q1_q  [DEPTH];
    logic [ROB_ID_W-1:0] q2_q  [DEPTH];
    logic [DATA_W-1:0]   v1_q  [DEPTH];
    logic [DATA_W-1:0]   v2_q  [DEPTH];
    logic [DATA_W-1:0]   imm_q [DEPTH];
    logic [ROB_ID_W-1:0] rob_q [DEPTH];

    // Returns {hit, data} for a tag on the CDBs; scanning from the top bus
    // down lets the lowest-numbered matching bus win.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [ROB_ID_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && tag != '0 && cdb_rob_id[k*ROB_ID_W +: ROB_ID_W] == tag)
                r = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    logic [DATA_W-1:0] head_addr;
    logic              head_is_io, head_ops_ok, issue, disp_acc, disp_cmt;
    logic [DATA_W:0]   cap1, cap2;
    logic [DEPTH-1:0]  cmt_hit;
    logic [CNT_W-1:0]  kept_cnt;

    assign head_addr   = v1_q[head_q] + imm_q[head_q];
    assign head_is_io  = (head_addr == IO_ADDR);
    assign head_ops_ok = busy_q[head_q] && q1_q[head_q] == '0 && q2_q[head_q] == '0;
    assign cap1        = cdb_lookup(disp_q1);
    assign cap2        = cdb_lookup(disp_q2);
    assign disp_cmt    = commit_valid && (commit_rob_id == disp_rob_id);

    always_comb begin
        issue = head_ops_ok && !lsu_busy &&
                (cmt_q[head_q] ||
                 (!st_q[head_q] && (!head_is_io || rob_head_id == rob_q[head_q])));
        // During a flush only a committed head may leave.
        if (flush && !cmt_q[head_q]) issue = 1'b0;
        disp_acc = disp_valid && !flush && (count_q != CNT_W'(DEPTH));

        for (int i = 0; i < DEPTH; i++)
            cmt_hit[i] = commit_valid && busy_q[i] && (rob_q[i] == commit_rob_id);

        busy_d = busy_q;
        cmt_d  = cmt_q | cmt_hit;
        if (issue) begin
            busy_d[head_q] = 1'b0;
            cmt_d[head_q]  = 1'b0;
        end
        if (disp_acc) begin
            busy_d[tail_q] = 1'b1;
            cmt_d[tail_q]  = disp_cmt;
        end
        if (flush) begin
            busy_d = busy_d & cmt_d;
            cmt_d  = cmt_d & busy_d;
        end

        // Entries surviving a flush, counted after the issue has been removed.
        kept_cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            kept_cnt = kept_cnt + CNT_W'(busy_d[i]);

        head_d = issue ? head_q + PTR_W'(1) : head_q;
        if (flush) begin
            count_d = kept_cnt;
            tail_d  = head_d + PTR_W'(kept_cnt);
        end else begin
            count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue);
            tail_d  = disp_acc ? tail_q + PTR_W'(1) : tail_q;
        end
    end

    // Control and issue registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            cmt_q        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            lsu_valid    <= 1'b0;
            lsu_op       <= '0;
            lsu_is_store <= 1'b0;
            lsu_addr     <= '0;
            lsu_wdata    <= '0;
            lsu_rob_id   <= '0;
        end else if (rdy) begin
            busy_q    <= busy_d;
            cmt_q     <= cmt_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            lsu_valid <= issue;
            if (issue) begin
                lsu_op       <= op_q[head_q];
                lsu_is_store <= st_q[head_q];
                lsu_addr     <= head_addr;
                lsu_wdata    <= st_q[head_q] ? v2_q[head_q] : '0;
                lsu_rob_id   <= rob_q[head_q];
            end
        end
    end

    // Entry payload: wakeup of waiting operands, then dispatch write at tail
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_lookup(q1_q[i]) >> DATA_W != '0) begin
                    q1_q[i] <= '0;
                    v1_q[i] <= cdb_lookup(q1_q[i]) [DATA_W-1:0];
                end
                if (busy_q[i] && cdb_lookup(q2_q[i]) >> DATA_W != '0) begin
                    q2_q[i] <= '0;
                    v2_q[i] <= cdb_lookup(q2_q[i]) [DATA_W-1:0];
                end
            end
            if (disp_acc) begin
                st_q[tail_q]  <= disp_is_store;
                op_q[tail_q]  <= disp_op;
                q1_q[tail_q]  <= cap1[DATA_W] ? '0 : disp_q1;
                v1_q[tail_q]  <= cap1[DATA_W] ? cap1[DATA_W-1:0] : disp_v1;
                q2_q[tail_q]  <= cap2[DATA_W] ? '0 : disp_q2;
                v2_q[tail_q]  <= cap2[DATA_W] ? cap2[DATA_W-1:0] : disp_v2;
                imm_q[tail_q] <= disp_imm;
                rob_q[tail_q] <= disp_rob_id;
            end
        end
    end

    assign io_rob_id = (busy_q[head_q] && q1_q[head_q] == '0 && head_is_io) ? rob_q[head_q] : '0;
    assign count     = count_q;
    assign full      = (count_q >= CNT_W'(DEPTH - FULL_MARGIN));

endmodule

// File: tb/tb_ls_queue_p.sv
module tb_ls_queue_p;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        disp_valid, disp_is_store;
    logic [3:0]  disp_op, disp_q1, disp_q2, disp_rob_id;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_data;
    logic        commit_valid;
    logic [3:0]  commit_rob_id, rob_head_id;
    logic        lsu_busy;
    logic        lsu_valid, lsu_is_store;
    logic [3:0]  lsu_op, lsu_rob_id, io_rob_id;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [4:0]  count;
    logic        full;

    ls_queue_p dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_op(disp_op),
        .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
        .disp_imm(disp_imm), .disp_rob_id(disp_rob_id),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id),
        .rob_head_id(rob_head_id), .lsu_busy(lsu_busy),
        .lsu_valid(lsu_valid), .lsu_op(lsu_op), .lsu_is_store(lsu_is_store),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rob_id(lsu_rob_id),
        .io_rob_id(io_rob_id), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rob;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Monitor: every issue pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t act, e;
        if (!rst && lsu_valid) begin
            act = '{lsu_op, lsu_is_store, lsu_addr, lsu_wdata, lsu_rob_id};
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected act=%h exp=none", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL issue act op=%h st=%b addr=%h wd=%h rob=%h exp op=%h st=%b addr=%h wd=%h rob=%h",
                             act.op, act.st, act.addr, act.wdata, act.rob,
                             e.op, e.st, e.addr, e.wdata, e.rob);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_disp(input logic st, input logic [3:0] op, input logic [3:0] rob,
                            input logic [3:0] q1, input logic [31:0] v1,
                            input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm);
        disp_valid = 1'b1; disp_is_store = st; disp_op = op; disp_rob_id = rob;
        disp_q1 = q1; disp_v1 = v1; disp_q2 = q2; disp_v2 = v2; disp_imm = imm;
    endtask

    task automatic dispatch(input logic st, input logic [3:0] op, input logic [3:0] rob,
                            input logic [3:0] q1, input logic [31:0] v1,
                            input logic [3:0] q2, input logic [31:0] v2, input logic [31:0] imm);
        set_disp(st, op, rob, q1, v1, q2, v2, imm);
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] op, input logic st, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] rob);
        sb.push_back('{op, st, addr, wdata, rob});
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_is_store = 1'b0; disp_op = '0; disp_q1 = '0; disp_q2 = '0;
        disp_v1 = '0; disp_v2 = '0; disp_imm = '0; disp_rob_id = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_data = '0;
        commit_valid = 1'b0; commit_rob_id = '0; rob_head_id = '0; lsu_busy = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset_count", 32'(count), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_lsu_valid", 32'(lsu_valid), 0);
        chk("reset_io_rob_id", 32'(io_rob_id), 0);

        // 1: load then store that waits for commit
        dispatch(1'b0, 4'h2, 4'h1, 4'h0, 32'h100, 4'h0, 32'h0, 32'h4);
        dispatch(1'b1, 4'h3, 4'h2, 4'h0, 32'h200, 4'h0, 32'hAB, 32'h0);
        chk("t1_count2", 32'(count), 2);
        push(4'h2, 1'b0, 32'h104, 32'h0, 4'h1);
        lsu_busy = 1'b0;
        tick(3);
        chk("t1_store_waits", 32'(count), 1);
        push(4'h3, 1'b1, 32'h200, 32'hAB, 4'h2);
        commit_valid = 1'b1; commit_rob_id = 4'h2;
        tick();
        commit_valid = 1'b0;
        tick(2);
        chk("t1_drained", 32'(count), 0);

        // 2: same-cycle capture from bus 1, later wakeup on bus 0
        lsu_busy = 1'b1;
        cdb_valid = 2'b11; cdb_rob_id = {4'd5, 4'd3}; cdb_data = {32'h40, 32'h999};
        dispatch(1'b0, 4'h4, 4'h3, 4'h5, 32'hDEAD, 4'h0, 32'h0, 32'h8);
        cdb_valid = 2'b00;
        dispatch(1'b1, 4'h5, 4'h4, 4'h0, 32'h300, 4'h7, 32'h0, 32'h10);
        push(4'h4, 1'b0, 32'h48, 32'h0, 4'h3);
        lsu_busy = 1'b0;
        tick(2);
        commit_valid = 1'b1; commit_rob_id = 4'h4;
        tick();
        commit_valid = 1'b0;
        tick(2);
        chk("t2_store_waits_q2", 32'(count), 1);
        push(4'h5, 1'b1, 32'h310, 32'h77, 4'h4);
        cdb_valid = 2'b11; cdb_rob_id = {4'd7, 4'd7}; cdb_data = {32'h99, 32'h77};
        tick();
        cdb_valid = 2'b00;
        tick(2);
        chk("t2_drained", 32'(count), 0);

        // 3: IO load gated by ROB head
        rob_head_id = 4'h0;
        dispatch(1'b0, 4'h1, 4'h6, 4'h0, 32'h30000, 4'h0, 32'h0, 32'h0);
        chk("t3_io_rob_id", 32'(io_rob_id), 6);
        tick(3);
        chk("t3_io_held", 32'(count), 1);
        push(4'h1, 1'b0, 32'h30000, 32'h0, 4'h6);
        rob_head_id = 4'h6;
        tick(2);
        chk("t3_io_issued", 32'(count), 0);
        chk("t3_io_rob_id_clear", 32'(io_rob_id), 0);
        rob_head_id = 4'h0;

        // 4: full flag, wrap, overflow ignored, dispatch+issue steady count
        lsu_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dispatch(1'b0, 4'h6, 4'(i + 1), 4'h0, 32'h1000 + 32'(i * 4), 4'h0, 32'h0, 32'h0);
            push(4'h6, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'(i + 1));
            if (i == 11) chk("t4_full_at12", 32'(full), 0);
            if (i == 12) chk("t4_full_at13", 32'(full), 1);
        end
        chk("t4_count16", 32'(count), 16);
        dispatch(1'b0, 4'h6, 4'hF, 4'h0, 32'hBAD0, 4'h0, 32'h0, 32'h0);
        chk("t4_overflow_ignored", 32'(count), 16);
        lsu_busy = 1'b0;
        tick(2);
        chk("t4_count14", 32'(count), 14);
        for (int i = 0; i < 3; i++) begin
            dispatch(1'b0, 4'h7, 4'(i + 8), 4'h0, 32'h2000 + 32'(i * 4), 4'h0, 32'h0, 32'h0);
            push(4'h7, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'(i + 8));
            chk("t4_steady_count", 32'(count), 14);
        end
        tick(20);
        chk("t4_drained", 32'(count), 0);

        // 5: flush keeps committed stores, drops the rest and the flush-cycle dispatch
        lsu_busy = 1'b1;
        dispatch(1'b1, 4'h8, 4'h1, 4'h0, 32'h500, 4'h0, 32'h11, 32'h0);
        dispatch(1'b1, 4'h8, 4'h2, 4'h0, 32'h504, 4'h0, 32'h22, 32'h0);
        dispatch(1'b0, 4'h9, 4'h3, 4'h0, 32'h600, 4'h0, 32'h0, 32'h0);
        dispatch(1'b1, 4'h8, 4'h4, 4'h0, 32'h700, 4'h0, 32'h44, 32'h0);
        commit_valid = 1'b1; commit_rob_id = 4'h1;
        tick();
        commit_rob_id = 4'h2;
        tick();
        commit_valid = 1'b0;
        chk("t5_count4", 32'(count), 4);
        flush = 1'b1;
        dispatch(1'b0, 4'h9, 4'h5, 4'h0, 32'h800, 4'h0, 32'h0, 32'h0);
        flush = 1'b0;
        chk("t5_flush_count", 32'(count), 2);
        push(4'h8, 1'b1, 32'h500, 32'h11, 4'h1);
        push(4'h8, 1'b1, 32'h504, 32'h22, 4'h2);
        lsu_busy = 1'b0;
        tick(4);
        chk("t5_stores_out", 32'(count), 0);
        dispatch(1'b0, 4'h9, 4'h6, 4'h0, 32'h900, 4'h0, 32'h0, 32'h0);
        push(4'h9, 1'b0, 32'h900, 32'h0, 4'h6);
        tick(2);
        chk("t5_tail_realigned", 32'(count), 0);

        // 6: reset mid-operation, then rdy low holds everything
        for (int i = 0; i < 5; i++)
            dispatch(1'b0, 4'hA, 4'(i + 1), 4'hA, 32'h0, 4'h0, 32'h0, 32'h0);
        chk("t6_count5", 32'(count), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_lsu_valid", 32'(lsu_valid), 0);
        rdy = 1'b0;
        set_disp(1'b0, 4'hB, 4'h3, 4'h0, 32'h55, 4'h0, 32'h0, 32'h0);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd3}; cdb_data = {32'h0, 32'h1};
        tick(2);
        disp_valid = 1'b0; cdb_valid = 2'b00;
        rdy = 1'b1;
        tick(2);
        chk("t6_rdy_low_no_disp", 32'(count), 0);
        dispatch(1'b0, 4'hC, 4'hC, 4'h9, 32'h0, 4'h0, 32'h0, 32'h8);
        rdy = 1'b0;
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h50};
        tick(2);
        cdb_valid = 2'b00;
        rdy = 1'b1;
        tick(2);
        chk("t6_rdy_low_no_wake", 32'(count), 1);
        push(4'hC, 1'b0, 32'h68, 32'h0, 4'hC);
        cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd9}; cdb_data = {32'h0, 32'h60};
        tick();
        cdb_valid = 2'b00;
        tick(2);
        chk("t6_woken_issued", 32'(count), 0);

        tick(3);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_queue_p.md
Name: ls_queue_p

Overview:
- Parametrised in-order load/store queue; the next generation of the LSB.
- Sits between dispatcher and LSU, monitors NUM_CDB result buses, and issues the head entry to the LSU when its operands are ready.
- Loads issue speculatively unless they target the IO address. Stores issue only after ROB commit.
- Adds mispredict flush: uncommitted entries are dropped and committed stores are retained.

Parameters:
DEPTH, 16, entry count; power of two, >=4
ROB_ID_W, 4, ROB tag width; tag 0 = "no dependency"
DATA_W, 32, data/address width
OP_W, 4, opcode width, passed through to the LSU
NUM_CDB, 2, number of result broadcast buses
FULL_MARGIN, 3, full asserts when count >= DEPTH-FULL_MARGIN
IO_ADDR, 32'h30000, memory-mapped IO address

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; when low, all state holds
flush  in  1  mispredict rollback
disp_valid  in  1  dispatch new entry at tail
disp_is_store  in  1  1 = store, 0 = load
disp_op  in  OP_W  opcode
disp_q1/disp_q2  in  ROB_ID_W  base/data source tags
disp_v1/disp_v2  in  DATA_W  base/data source values
disp_imm  in  DATA_W  offset
disp_rob_id  in  ROB_ID_W  entry's ROB tag
cdb_valid  in  NUM_CDB  per-bus valid
cdb_rob_id  in  NUM_CDB*ROB_ID_W  flat packed, bus k at [k*ROB_ID_W +: ROB_ID_W]
cdb_data  in  NUM_CDB*DATA_W  flat packed
commit_valid  in  1  ROB committing an entry
commit_rob_id  in  ROB_ID_W  committed tag
rob_head_id  in  ROB_ID_W  tag currently at ROB head
lsu_busy  in  1  LSU cannot accept
lsu_valid  out  1  issue pulse, registered
lsu_op  out  OP_W  registered
lsu_is_store  out  1  registered
lsu_addr  out  DATA_W  v1+imm, registered
lsu_wdata  out  DATA_W  v2 for stores, 0 for loads
lsu_rob_id  out  ROB_ID_W  registered
io_rob_id  out  ROB_ID_W  combinational: head tag if the head entry is busy, q1==0 and its address==IO_ADDR, else 0
count  out  $clog2(DEPTH)+1  occupancy
full  out  1  combinational from count

Behaviour:
- **Reset:** all entries not busy, committed=0, head=tail=0, count=0. All lsu_* outputs 0. rdy is ignored during reset.
- **rdy low:** nothing changes; lsu_valid holds its registered value.
- **Storage:** circular queue occupying [head, tail). head/tail wrap DEPTH-1 -> 0.
- **Dispatch:** when disp_valid && !flush, write the entry at tail and advance tail.
  - Source capture is same-cycle: if any cdb_valid[k] with a tag equal to a nonzero disp_q, store q=0 and v=cdb_data[k].
  - If several buses match, the lowest k wins.
  - The dispatcher must honour full; dispatch while count==DEPTH is ignored.
- **Wakeup:** each cycle, every busy entry with q!=0 matching a valid CDB tag gets q<=0 and v<=data (lowest k wins).
- **Commit:** a busy entry whose rob_id==commit_rob_id sets committed=1. An entry dispatched in the same cycle with that tag is also marked committed.
- **Issue condition** (combinational) requires all of:
  - head busy, q1==0, q2==0, !lsu_busy;
  - and either:
    - committed; or
    - load with address != IO_ADDR; or
    - load with address == IO_ADDR and rob_head_id == head rob_id.
- **Issue cycle:**
  - Next cycle: lsu_valid=1 and all lsu_* outputs loaded from the head entry.
  - The head entry is cleared and head advances.
  - lsu_valid is a single-cycle pulse; otherwise 0.
- **Count:** count <= count + accepted_dispatch - issue. Simultaneous dispatch and issue leaves count unchanged.
- **Flush:**
  - Every entry with committed=0 is cleared. Committed entries are contiguous from head and are kept.
  - tail <= head' + C, where head' is head after any issue in the same cycle and C = committed entries retained.
  - count <= C.
  - Dispatch in the flush cycle is dropped.
  - Issue in the flush cycle proceeds only if the head is committed; a speculative load is not issued.
- **Arithmetic:** address and width arithmetic is mod 2^DATA_W. No overflow flag.

Test Plan:
1. **Load then store with commit:** reset; dispatch load (q=0, v1=0x100, imm=4), then store (v1=0x200, v2=0xAB).
   - Load: lsu_valid pulse one cycle after head-ready with lsu_addr=0x104, lsu_wdata=0.
   - Store: no issue until commit_rob_id matches; then lsu_addr=0x200, lsu_wdata=0xAB, lsu_is_store=1.
2. **CDB wakeup/capture:**
   - Dispatch with q1=5 in the same cycle cdb[1] broadcasts tag 5 data 0x40 -> entry stored ready, lsu_addr=0x40+imm.
   - Later entry with q2=7 wakes when cdb[0] broadcasts tag 7.
3. **IO gating:** load at address 0x30000.
   - io_rob_id = its tag; no issue while rob_head_id differs.
   - Issues the cycle after rob_head_id matches.
4. **Full/wrap:**
   - Dispatch 13 entries with DEPTH=16 -> full=1 at count 13.
   - Drain and refill past index 15 -> tail wraps to 0; FIFO order preserved.
   - Simultaneous dispatch+issue keeps count constant.
5. **Flush:** queue holds committed store, committed store, uncommitted load, uncommitted store.
   - Flush -> count=2, tail=head+2.
   - Both stores still issue in order.
   - A dispatch in the flush cycle is absent.
6. **Reset mid-operation and rdy:** assert rst with 5 entries and lsu_busy=0.
   - Next cycle count=0, lsu_valid=0.
   - With rdy=0, dispatch and CDB are ignored and state is unchanged.
